// File: rtl/region_frame_tx.sv
// region_frame_tx: serializes one region record into a paced, framed byte stream and waits for ack.
// Define REGION_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module region_frame_tx #(
  parameter int NUM_SHAPES  = 6,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_w,
  input  logic [7:0]              in_h,
  input  logic [8*NUM_SHAPES-1:0] in_counts,
  output logic [7:0]              tx_data,
  output logic                    tx_strobe,
  output logic                    tx_last,
  input  logic                    ack_in,
  output logic                    done,
  output logic                    timeout
);
`ifdef REGION_TX_CHECKSUM_EN
  localparam int NB = NUM_SHAPES + 4;
  logic [7:0] w_csum;
  always_comb begin
    w_csum = 8'hA5 ^ in_w ^ in_h;
    for (int k = 0; k < NUM_SHAPES; k++) w_csum = w_csum ^ in_counts[8*k +: 8];
  end
  logic [8*NB-1:0] w_frame;
  assign w_frame = {w_csum, in_counts, in_h, in_w, 8'hA5};
`else
  localparam int NB = NUM_SHAPES + 3;
  logic [8*NB-1:0] w_frame;
  assign w_frame = {in_counts, in_h, in_w, 8'hA5};
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_strobe;
  logic            r_last;
  logic            r_done;
  logic            r_timeout;
  logic [7:0]      r_data;
  logic [4:0]      r_idx;
  logic [15:0]     r_cnt;
  logic [8*NB-1:0] r_buf;

  logic [4:0] w_next;
  logic       w_gap_end;
  logic       w_step;

  assign w_next    = r_idx + 5'd1;
  assign w_gap_end = (r_state == S_GAP) && (r_cnt == 16'(GAP_CYCLES - 1));
  // the current byte's slot (strobe plus gap) ends this cycle
  assign w_step    = ((r_state == S_SEND) && (GAP_CYCLES == 0)) || w_gap_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_strobe  <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= 8'h00;
      r_idx     <= 5'd0;
      r_cnt     <= 16'd0;
      r_buf     <= '0;
    end else begin
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= ~(in_valid & r_ready);
          if (in_valid && r_ready) begin
            r_buf    <= w_frame;
            r_data   <= 8'hA5;
            r_strobe <= 1'b1;
            r_last   <= 1'b0;
            r_idx    <= 5'd0;
            r_state  <= S_SEND;
          end
        end
        S_SEND, S_GAP: begin
          r_cnt <= (w_step || r_state == S_SEND) ? 16'd0 : r_cnt + 16'd1;
          if (w_step && r_last) r_state <= S_WAIT;
          else if (w_step) begin
            r_idx    <= w_next;
            r_data   <= 8'(r_buf >> {w_next, 3'b000});
            r_last   <= (w_next == 5'(NB - 1));
            r_strobe <= 1'b1;
            r_state  <= S_SEND;
          end else r_state <= S_GAP;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (ack_in) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt == 16'(ACK_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_last stays set through the trailing gap, so tx_last is qualified by the strobe
  assign in_ready  = r_ready & ~rst;
  assign tx_data   = r_data;
  assign tx_strobe = r_strobe;
  assign tx_last   = r_strobe & r_last;
  assign done      = r_done;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_region_frame_tx.sv
// tb_region_frame_tx: two DUT configs (gap 2 / timeout 10, gap 0 / timeout 20) on shared stimulus,
// each checked every cycle against a frame-timeline model, plus literal checks of directed frames.
module tb_region_frame_tx;
  localparam int NS = 6;
`ifdef REGION_TX_CHECKSUM_EN
  localparam int NB = NS + 4;
`else
  localparam int NB = NS + 3;
`endif

  logic clk = 0, rst = 1, in_valid = 0, ack_in = 0;
  logic [7:0] in_w = 0, in_h = 0;
  logic [8*NS-1:0] in_counts = '0;
  int cyc = 0, n_tests = 0, n_fail = 0;
  logic [7:0] lit [10] = '{8'hA5, 8'h0C, 8'h05, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'hAC};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : c
    localparam int G  = (g == 0) ? 2 : 0;
    localparam int T  = (g == 0) ? 10 : 20;
    localparam int W0 = NB * (G + 1) + 1;
    logic rdy, strb, last, dn, to;
    logic [7:0] dat;
    int t = 0;
    bit mr = 0;
    logic [7:0] fr [NB];
    logic [7:0] e_data = 0;
    bit e_strobe, e_last, e_done, e_to;
    int sc[$], dc[$], tc[$];
    logic [7:0] sb[$];
    bit sl[$];

    region_frame_tx #(.NUM_SHAPES(NS), .GAP_CYCLES(G), .ACK_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
      .in_w(in_w), .in_h(in_h), .in_counts(in_counts),
      .tx_data(dat), .tx_strobe(strb), .tx_last(last),
      .ack_in(ack_in), .done(dn), .timeout(to));

    // t = cycles since accept; bytes occupy t=1..W0-1, ack window is t=W0..W0+T-1
    always @(posedge clk) begin
      e_strobe = 0; e_last = 0; e_done = 0; e_to = 0;
      if (rst) begin
        t = 0; mr = 1; e_data = 0;
      end else if (t == 0) begin
        if (mr && in_valid) begin
          fr[0] = 8'hA5; fr[1] = in_w; fr[2] = in_h;
          for (int k = 0; k < NS; k++) fr[k+3] = in_counts[8*k +: 8];
`ifdef REGION_TX_CHECKSUM_EN
          fr[NB-1] = 8'h00;
          for (int k = 0; k < NB - 1; k++) fr[NB-1] = fr[NB-1] ^ fr[k];
`endif
          t = 1; mr = 0;
        end else mr = 1;
      end else if (t >= W0) begin
        if (ack_in) begin e_done = 1; t = 0; end
        else if (t == W0 + T - 1) begin e_to = 1; t = 0; end
        else t++;
      end else t++;
      if (t > 0 && t < W0 && (t - 1) % (G + 1) == 0) begin
        e_strobe = 1;
        e_data = fr[(t - 1) / (G + 1)];
        e_last = ((t - 1) / (G + 1) == NB - 1);
      end
      #1;
      check($sformatf("c%0d in_ready", g), rdy, (t == 0 && mr && !rst));
      check($sformatf("c%0d tx_data", g), dat, e_data);
      check($sformatf("c%0d tx_strobe", g), strb, e_strobe);
      check($sformatf("c%0d tx_last", g), last, e_last);
      check($sformatf("c%0d done", g), dn, e_done);
      check($sformatf("c%0d timeout", g), to, e_to);
      if (strb) begin sc.push_back(cyc); sb.push_back(dat); sl.push_back(last); end
      if (dn) dc.push_back(cyc);
      if (to) tc.push_back(cyc);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!(c[0].rdy && c[1].rdy) && k < 300) begin @(negedge clk); k++; end
    check("wait ready", {c[0].rdy, c[1].rdy}, 2'b11);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w, input logic [7:0] h, input logic [8*NS-1:0] cnt, output int a);
    in_w = w; in_h = h; in_counts = cnt; in_valid = 1; a = cyc;
    @(negedge clk);
    in_valid = 0;
    in_w = 8'($urandom); in_h = 8'($urandom); in_counts = 48'({$urandom, $urandom});
  endtask

  initial begin : stim
    int a, b0, b1, d0, t0, lc;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    check("idle strobes", c[0].sc.size() + c[1].sc.size(), 0);
    check("idle ready", c[0].rdy, 1);
    check("idle data", c[0].dat, 0);

    // directed frame; in_w changes right after accept to prove latching
    wait_ready();
    b0 = c[0].sc.size(); b1 = c[1].sc.size(); d0 = c[0].dc.size();
    send(8'h0C, 8'h05, {8'd2, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1}, a);
    wait_cyc(a + 1 + 3 * NB);
    check("c0 strobe count", c[0].sc.size() - b0, NB);
    check("c1 strobe count", c[1].sc.size() - b1, NB);
    if (c[0].sc.size() - b0 == NB && c[1].sc.size() - b1 == NB)
      for (int n = 0; n < NB; n++) begin
        check($sformatf("c0 byte%0d", n), c[0].sb[b0+n], lit[n]);
        check($sformatf("c0 time%0d", n), c[0].sc[b0+n] - a, 1 + 3 * n);
        check($sformatf("c0 last%0d", n), c[0].sl[b0+n], n == NB - 1);
        check($sformatf("c1 byte%0d", n), c[1].sb[b1+n], lit[n]);
        check($sformatf("c1 time%0d", n), c[1].sc[b1+n] - a, 1 + n);
      end
    lc = a + 1 + 3 * (NB - 1);
    wait_cyc(lc + 5);
    ack_in = 1;
    @(negedge clk);
    ack_in = 0;
    wait_cyc(lc + 7);
    check("c0 done cycle", (c[0].dc.size() == d0 + 1) ? c[0].dc[d0] : -1, lc + 6);
    check("c0 ready after done", c[0].rdy, 1);

    // timeout with a spurious ack during the first strobe
    wait_ready();
    d0 = c[0].dc.size(); t0 = c[0].tc.size();
    send(8'($urandom), 8'($urandom), 48'({$urandom, $urandom}), a);
    ack_in = 1;
    @(negedge clk);
    ack_in = 0;
    wait_cyc(a + 3 * NB + 13);
    check("c0 timeout count", c[0].tc.size() - t0, 1);
    check("c0 timeout cycle", (c[0].tc.size() == t0 + 1) ? c[0].tc[t0] - a : -1, 3 * NB + 11);
    check("c0 no done", c[0].dc.size() - d0, 0);
    check("c0 ready after timeout", c[0].rdy, 1);

    // ack on the final cycle of the window beats the timeout
    wait_ready();
    d0 = c[0].dc.size(); t0 = c[0].tc.size();
    send(8'($urandom), 8'($urandom), 48'({$urandom, $urandom}), a);
    wait_cyc(a + 3 * NB + 10);
    ack_in = 1;
    @(negedge clk);
    ack_in = 0;
    wait_cyc(a + 3 * NB + 13);
    check("race done cycle", (c[0].dc.size() == d0 + 1) ? c[0].dc[d0] - a : -1, 3 * NB + 11);
    check("race no timeout", c[0].tc.size() - t0, 0);

    // reset after the 4th strobe, then a clean restart
    wait_ready();
    b0 = c[0].sc.size();
    send(8'($urandom), 8'($urandom), 48'({$urandom, $urandom}), a);
    wait_cyc(a + 10);
    check("c0 four strobes", c[0].sc.size() - b0, 4);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post-reset data", c[0].dat, 0);
    check("post-reset ready", c[0].rdy, 1);
    check("post-reset strobes", c[0].sc.size() - b0, 4);
    wait_ready();
    send(8'h33, 8'h44, 48'({$urandom, $urandom}), a);
    wait_cyc(a + 2);
    check("restart header", (c[0].sc.size() == b0 + 5) ? c[0].sb[b0+4] : 8'h00, 8'hA5);
    check("restart time", (c[0].sc.size() == b0 + 5) ? c[0].sc[b0+4] - a : -1, 1);

    // randomized traffic, acks and occasional resets
    for (int i = 0; i < 2500; i++) begin
      in_valid  = ($urandom % 3 == 0);
      in_w      = 8'($urandom);
      in_h      = 8'($urandom);
      in_counts = 48'({$urandom, $urandom});
      ack_in    = ($urandom % 7 == 0);
      rst       = ($urandom % 400 == 0);
      @(negedge clk);
    end
    rst = 0; in_valid = 0; ack_in = 0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
